// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin scheduler sharing one UART transmitter among N_REQ clients.
// Each client offers a byte and its own frame configuration. The arbiter
// grants one client at a time and drives the UART data and configuration
// inputs. When the configuration changes it holds it for SETTLE cycles before
// starting the frame. It then tracks the frame through uart_busy and returns
// the UART error code.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   defined   -> watchdog in WAIT_BUSY. If uart_busy has not risen BUSY_TO
//                cycles after uart_start, the frame ends with
//                frame_err = 3'b111 and a timeout pulse.
//   undefined -> no watchdog. WAIT_BUSY waits forever, timeout is tied to 0
//                and BUSY_TO is only range-checked.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   req          per-client request level                      [N_REQ]
//   req_data     client i byte at [8i+7:8i]                     [8*N_REQ]
//   req_cfg      client i {bd_rate,par,d_num,s_num} at [6i+5:6i] [6*N_REQ]
//   gnt          one-hot, one-cycle accept pulse                [N_REQ]
//   uart_busy    UART shifting a frame
//   uart_err     UART error code, valid when uart_busy falls    [3]
//   uart_start   one-cycle frame start pulse to the UART
//   data_in      byte to the UART                               [8]
//   bd_rate/par/d_num/s_num  applied UART configuration
//   owner        index of the last granted client               [CW]
//   frame_done   one-cycle pulse at frame end
//   frame_err    error code of the last finished frame          [3]
//   timeout      one-cycle pulse when the busy watchdog expires
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int CW      = 2,
    parameter int SETTLE  = 16,
    parameter int BUSY_TO = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [6*N_REQ-1:0]   req_cfg,
    output logic [N_REQ-1:0]     gnt,
    input  logic                 uart_busy,
    input  logic [2:0]           uart_err,
    output logic                 uart_start,
    output logic [7:0]           data_in,
    output logic [1:0]           bd_rate,
    output logic [1:0]           par,
    output logic                 d_num,
    output logic                 s_num,
    output logic [CW-1:0]        owner,
    output logic                 frame_done,
    output logic [2:0]           frame_err,
    output logic                 timeout
);

    // Reject illegal parameter sets at elaboration.
    if (N_REQ < 2 || N_REQ > 8 || CW != $clog2(N_REQ) ||
        SETTLE < 1 || SETTLE > 255 || BUSY_TO < 1 || BUSY_TO > 255) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_START, S_WAIT_BUSY, S_WAIT_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   gnt_reg, gnt_next;
    logic               uart_start_reg, uart_start_next;
    logic [7:0]         data_reg, data_next;
    logic [5:0]         cfg_reg, cfg_next;        // applied {bd_rate, par, d_num, s_num}
    logic [CW-1:0]      owner_reg, owner_next;
    logic [CW-1:0]      rr_ptr_reg, rr_ptr_next;
    logic               frame_done_reg, frame_done_next;
    logic [2:0]         frame_err_reg, frame_err_next;
    logic [7:0]         cnt_reg, cnt_next;        // settle countdown
`ifdef UART_ARB_TIMEOUT_EN
    logic [7:0]         wd_reg, wd_next;          // cycles spent waiting for busy
    logic               timeout_reg, timeout_next;
`endif

    // Per-client views of the packed request buses.
    logic [5:0] cfg_arr  [N_REQ];
    logic [7:0] data_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign cfg_arr[gi]  = req_cfg[6*gi +: 6];
        assign data_arr[gi] = req_data[8*gi +: 8];
    end

    // Round-robin pick: first requesting client at or above rr_ptr, wrapping.
    logic           win_found;
    logic [CW-1:0]  win_idx;
    logic           cfg_changed;

    always_comb begin
        logic [CW:0] scan;
        scan      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan = {1'b0, rr_ptr_reg} + (CW+1)'(i);
            if (scan >= (CW+1)'(N_REQ)) begin
                scan = scan - (CW+1)'(N_REQ);
            end
            if (!win_found && req[scan[CW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[CW-1:0];
            end
        end
    end

    assign cfg_changed = (cfg_arr[win_idx] != cfg_reg);

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            gnt_reg        <= '0;
            uart_start_reg <= 1'b0;
            data_reg       <= '0;
            cfg_reg        <= '0;
            owner_reg      <= '0;
            rr_ptr_reg     <= '0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= '0;
            cnt_reg        <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_reg         <= '0;
            timeout_reg    <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            gnt_reg        <= gnt_next;
            uart_start_reg <= uart_start_next;
            data_reg       <= data_next;
            cfg_reg        <= cfg_next;
            owner_reg      <= owner_next;
            rr_ptr_reg     <= rr_ptr_next;
            frame_done_reg <= frame_done_next;
            frame_err_reg  <= frame_err_next;
            cnt_reg        <= cnt_next;
`ifdef UART_ARB_TIMEOUT_EN
            wd_reg         <= wd_next;
            timeout_reg    <= timeout_next;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (win_found) state_next = cfg_changed ? S_SETTLE : S_START;
            S_SETTLE:    if (cnt_reg == 8'd0) state_next = S_START;
            S_START:     state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                // A busy rise in the same cycle as watchdog expiry wins.
                if (uart_busy) begin
                    state_next = S_WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (wd_reg == 8'(BUSY_TO - 1)) begin
                    state_next = S_IDLE;
                end
`endif
            end
            S_WAIT_DONE: if (!uart_busy) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Output / datapath next values. Pulses default low; everything else holds.
    always_comb begin
        gnt_next        = '0;
        uart_start_next = 1'b0;
        frame_done_next = 1'b0;
        data_next       = data_reg;
        cfg_next        = cfg_reg;
        owner_next      = owner_reg;
        rr_ptr_next     = rr_ptr_reg;
        frame_err_next  = frame_err_reg;
        cnt_next        = cnt_reg;
`ifdef UART_ARB_TIMEOUT_EN
        wd_next         = wd_reg;
        timeout_next    = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (win_found) begin
                    gnt_next    = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    data_next   = data_arr[win_idx];
                    cfg_next    = cfg_arr[win_idx];
                    owner_next  = win_idx;
                    rr_ptr_next = (win_idx == CW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                    cnt_next    = 8'(SETTLE - 1);
                end
            end
            S_SETTLE: begin
                if (cnt_reg != 8'd0) cnt_next = cnt_reg - 8'd1;
            end
            S_START: begin
                uart_start_next = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                wd_next         = '0;
`endif
            end
            S_WAIT_BUSY: begin
`ifdef UART_ARB_TIMEOUT_EN
                if (!uart_busy) begin
                    if (wd_reg == 8'(BUSY_TO - 1)) begin
                        timeout_next    = 1'b1;
                        frame_done_next = 1'b1;
                        frame_err_next  = 3'b111;
                    end else begin
                        wd_next = wd_reg + 8'd1;
                    end
                end
`endif
            end
            S_WAIT_DONE: begin
                if (!uart_busy) begin
                    frame_err_next  = uart_err;
                    frame_done_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign gnt        = gnt_reg;
    assign uart_start = uart_start_reg;
    assign data_in    = data_reg;
    assign bd_rate    = cfg_reg[5:4];
    assign par        = cfg_reg[3:2];
    assign d_num      = cfg_reg[1];
    assign s_num      = cfg_reg[0];
    assign owner      = owner_reg;
    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout    = timeout_reg;
`else
    assign timeout    = 1'b0;
`endif

endmodule
